// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: queues hold/reset/set/toggle commands in a small FIFO and
// drives each one onto registered j/k outputs for cmd_len+1 cycles, with
// back-to-back commands playing without a gap.
// Optional feature macro: QCHECK_EN adds a JK reference model that compares
// the flop's q_fb against the expected value and raises a sticky err flag.
//
// state | meaning
// IDLE  | no command active, j=k=0 (flop holds), waiting for FIFO data
// DRIVE | a command is on j/k, rem counts down the remaining drive cycles
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             done,
  input  logic             q_fb,
  output logic             err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CMD_W = 2 + LEN_W;

  typedef enum logic {IDLE, DRIVE} state_t;

  logic [CMD_W-1:0] fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             full, empty, push, pop;
  logic [CMD_W-1:0] head;

  state_t           state_q, state_d;
  logic             j_q, j_d, k_q, k_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [LEN_W-1:0] rem_q, rem_d;

  assign full      = (count_q == (PTR_W+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign cmd_ready = !full && rst_n;
  assign push      = cmd_valid && cmd_ready;
  assign head      = fifo_q[rd_ptr_q];

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {cmd_op, cmd_len};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + (PTR_W+1)'(1);
      else if (pop && !push) count_q <= count_q - (PTR_W+1)'(1);
    end
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state: pop from IDLE, or chain straight into the next command at rem==0
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    k_d     = k_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rem_d   = rem_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          {j_d, k_d} = head[CMD_W-1 -: 2];
          rem_d      = head[LEN_W-1:0];
          busy_d     = 1'b1;
          state_d    = DRIVE;
        end
      end
      DRIVE: begin
        if (rem_q != '0) begin
          rem_d = rem_q - LEN_W'(1);
        end else begin
          done_d = 1'b1;
          if (!empty) begin
            pop        = 1'b1;
            {j_d, k_d} = head[CMD_W-1 -: 2];
            rem_d      = head[LEN_W-1:0];
          end else begin
            j_d     = 1'b0;
            k_d     = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign j    = j_q;
  assign k    = k_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef QCHECK_EN
  logic q_exp_q, v_q, err_q;

  // Reference JK model fed by the registered j/k; err latches any valid mismatch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_exp_q <= 1'b0;
      v_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (v_q && (q_fb != q_exp_q)) err_q <= 1'b1;
      case ({j_q, k_q})
        2'b01: begin q_exp_q <= 1'b0; v_q <= 1'b1; end
        2'b10: begin q_exp_q <= 1'b1; v_q <= 1'b1; end
        2'b11: q_exp_q <= ~q_exp_q;
        default: ;
      endcase
    end
  end

  assign err = err_q;
`else
  logic unused_q_fb;
  assign unused_q_fb = q_fb;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer: a vector table covering reset, a single
// command and a back-to-back chain, then hand sequences for FIFO-full
// back-pressure, reset mid-command and the q_fb check flag.
module tb_jk_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_len;
  logic       j, k, busy, done, q_fb, err;
  logic       q_flop = 1'b0;
  logic       force_en = 1'b0;
  logic       force_val = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;

  jk_cmd_sequencer #(.DEPTH(4), .LEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .j(j), .k(k), .busy(busy),
    .done(done), .q_fb(q_fb), .err(err)
  );

  always #5 clk = ~clk;

  // Stand-in for the downstream JK flip-flop
  always @(posedge clk) begin
    case ({j, k})
      2'b01: q_flop <= 1'b0;
      2'b10: q_flop <= 1'b1;
      2'b11: q_flop <= ~q_flop;
      default: ;
    endcase
  end
  assign q_fb = force_en ? force_val : q_flop;

  typedef struct {
    logic       rst_n;
    logic       valid;
    logic [1:0] op;
    logic [3:0] len;
    logic [4:0] exp;   // {cmd_ready, j, k, busy, done}
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [1:0] op, input logic [3:0] len);
    @(negedge clk);
    rst_n     = r;
    cmd_valid = v;
    cmd_op    = op;
    cmd_len   = len;
    #1;
  endtask

  int         acc;
  int         acc_idx [6];
  int         n_done;
  logic       exp_err;
  logic       saw_bad;

  initial begin
    // rst | valid | op | len | {ready,j,k,busy,done}
    tbl[0]  = '{1'b0, 1'b1, 2'b10, 4'd0, 5'b00000};
    tbl[1]  = '{1'b0, 1'b1, 2'b10, 4'd0, 5'b00000};
    tbl[2]  = '{1'b1, 1'b0, 2'b00, 4'd0, 5'b10000};
    tbl[3]  = '{1'b1, 1'b0, 2'b00, 4'd0, 5'b10000};
    tbl[4]  = '{1'b1, 1'b1, 2'b10, 4'd2, 5'b10000};
    tbl[5]  = '{1'b1, 1'b0, 2'b00, 4'd0, 5'b10000};
    tbl[6]  = '{1'b1, 1'b0, 2'b00, 4'd0, 5'b11010};
    tbl[7]  = '{1'b1, 1'b0, 2'b00, 4'd0, 5'b11010};
    tbl[8]  = '{1'b1, 1'b0, 2'b00, 4'd0, 5'b11010};
    tbl[9]  = '{1'b1, 1'b0, 2'b00, 4'd0, 5'b10001};
    tbl[10] = '{1'b1, 1'b0, 2'b00, 4'd0, 5'b10000};
    tbl[11] = '{1'b1, 1'b1, 2'b10, 4'd0, 5'b10000};
    tbl[12] = '{1'b1, 1'b1, 2'b11, 4'd3, 5'b10000};
    tbl[13] = '{1'b1, 1'b1, 2'b01, 4'd0, 5'b11010};
    tbl[14] = '{1'b1, 1'b0, 2'b00, 4'd0, 5'b11111};
    tbl[15] = '{1'b1, 1'b0, 2'b00, 4'd0, 5'b11110};
    tbl[16] = '{1'b1, 1'b0, 2'b00, 4'd0, 5'b11110};
    tbl[17] = '{1'b1, 1'b0, 2'b00, 4'd0, 5'b11110};
    tbl[18] = '{1'b1, 1'b0, 2'b00, 4'd0, 5'b10111};
    tbl[19] = '{1'b1, 1'b0, 2'b00, 4'd0, 5'b10001};
    tbl[20] = '{1'b1, 1'b0, 2'b00, 4'd0, 5'b10000};

`ifdef QCHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif

    rst_n = 1'b0; cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 4'd0;
    @(posedge clk);

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].rst_n, tbl[i].valid, tbl[i].op, tbl[i].len);
      chk($sformatf("vec%0d", i), {3'b0, cmd_ready, j, k, busy, done}, {3'b0, tbl[i].exp});
    end
    chk("err_after_table", {7'b0, err}, 8'd0);

    // Fill the FIFO behind a long toggle; the sixth push waits for the first pop
    acc = 0;
    n_done = 0;
    for (int i = 0; i < 6; i++) acc_idx[i] = -1;
    for (int c = 0; c < 60; c++) begin
      drive(1'b1, acc < 6, 2'b11, (acc == 0) ? 4'd15 : 4'd0);
      if (done) n_done++;
      if (c == 10) chk("full_ready_low", {6'b0, cmd_ready, busy}, 8'b01);
      if (c == 16) chk("drive16_jk", {5'b0, j, k, busy}, 8'b111);
      if (cmd_valid && cmd_ready) begin
        acc_idx[acc] = c;
        acc++;
      end
    end
    chk("fifth_push_cycle", 8'(acc_idx[4]), 8'd4);
    chk("sixth_push_cycle", 8'(acc_idx[5]), 8'd18);
    chk("full_done_count", 8'(n_done), 8'd6);
    chk("full_drained", {5'b0, busy, j, k}, 8'd0);

    // Reset in drive cycle 4 of a long command with a second command queued
    drive(1'b1, 1'b1, 2'b11, 4'd10);
    drive(1'b1, 1'b0, 2'b00, 4'd0);
    drive(1'b1, 1'b0, 2'b00, 4'd0);
    drive(1'b1, 1'b1, 2'b10, 4'd0);
    drive(1'b1, 1'b0, 2'b00, 4'd0);
    chk("pre_abort_drive", {5'b0, j, k, busy}, 8'b111);
    drive(1'b0, 1'b0, 2'b00, 4'd0);
    chk("abort_ready_low", {7'b0, cmd_ready}, 8'd0);
    drive(1'b1, 1'b0, 2'b00, 4'd0);
    chk("after_abort", {4'b0, j, k, busy, done}, 8'd0);
    saw_bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b0, 2'b00, 4'd0);
      if (done || busy || j || k) saw_bad = 1'b1;
    end
    chk("abort_no_done_no_drive", {7'b0, saw_bad}, 8'd0);

    // Set the flop, then feed back a wrong q
    drive(1'b1, 1'b1, 2'b10, 4'd0);
    drive(1'b1, 1'b0, 2'b00, 4'd0);
    drive(1'b1, 1'b0, 2'b00, 4'd0);
    chk("set_drive", {5'b0, j, k, busy}, 8'b101);
    drive(1'b1, 1'b0, 2'b00, 4'd0);
    chk("err_before_force", {7'b0, err}, 8'd0);
    force_val = 1'b0;
    force_en  = 1'b1;
    drive(1'b1, 1'b0, 2'b00, 4'd0);
    force_en  = 1'b0;
    chk("err_set", {7'b0, err}, {7'b0, exp_err});
    for (int c = 0; c < 4; c++) drive(1'b1, 1'b0, 2'b00, 4'd0);
    chk("err_sticky", {7'b0, err}, {7'b0, exp_err});
    drive(1'b0, 1'b0, 2'b00, 4'd0);
    drive(1'b1, 1'b0, 2'b00, 4'd0);
    chk("err_cleared_by_reset", {7'b0, err}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
